sg_sequencer: RTL

Step sequencer that drives the signal generator's register-write port (strobe, 3-bit address, 5-bit data). It holds up to 8 programmed (address, data) steps and plays them back as single-cycle write strobes spaced by a programmable cycle interval. This lets a pattern of register writes run autonomously instead of being strobed by hand from the pins. It sits between the top-level pin decode and the signal generator's write interface.

---
 rtl/sg_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sg_sequencer.sv
// sg_sequencer: eight-entry register-write step sequencer for the signal generator.
// Plays stored (address, data) steps back as single-cycle write strobes.
// The steps are spaced by a programmable interval.
// Build option: define SEQ_LOOP_EN to repeat the sequence until stop or reset.
// Without it, playback ends after one pass and pulses done.
//
// Host write port: host_we is a plain write enable with no back-pressure.
// Every cycle with host_we=1 writes host_wdata into store[host_sel] at that edge.
// The step store is writable in any state.
// A write that lands on the same edge that loads that step to the outputs
// issues the old contents.
module sg_sequencer #(
    parameter int STEPS = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_we,
    input  logic [2:0]       host_sel,
    input  logic [7:0]       host_wdata,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       length,
    input  logic [DIV_W-1:0] interval,
    output logic             sg_write_strobe,
    output logic [2:0]       sg_address,
    output logic [4:0]       sg_data,
    output logic             busy,
    output logic [2:0]       step_idx,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       store_q [STEPS];
    logic [2:0]       len_q, len_d;
    logic [DIV_W-1:0] int_q, int_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       addr_q, addr_d;
    logic [4:0]       data_q, data_d;
    logic             strobe_q;
    logic             busy_q;
    logic             done_q, done_d;

    logic [2:0]       nxt_idx;
    logic [7:0]       first_entry;
    logic [7:0]       next_entry;

    // Step store: host writes land on the clock edge, independent of playback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                store_q[i] <= 8'h00;
            end
        end else if (host_we) begin
            store_q[host_sel] <= host_wdata;
        end
    end

    // Store read ports: step 0 and the step following the current one.
    always_comb begin
        nxt_idx     = idx_q + 3'd1;
        first_entry = store_q[0];
        next_entry  = store_q[nxt_idx];
    end

    // Next-state and next-output logic; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        int_d   = int_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ISSUE;
                        len_d   = length;
                        int_d   = interval;
                        idx_d   = 3'd0;
                        addr_d  = first_entry[2:0];
                        data_d  = first_entry[7:3];
                    end
                end
                ISSUE: begin
                    // An interval of 0 behaves as 1: counter starts at 0.
                    state_d = WAIT;
                    if (int_q == '0) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = int_q - CNT_ONE;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (idx_q < len_q) begin
                        state_d = ISSUE;
                        idx_d   = nxt_idx;
                        addr_d  = next_entry[2:0];
                        data_d  = next_entry[7:3];
                    end else begin
`ifdef SEQ_LOOP_EN
                        // Wrap to step 0 with the usual spacing.
                        state_d = ISSUE;
                        idx_d   = 3'd0;
                        addr_d  = first_entry[2:0];
                        data_d  = first_entry[7:3];
`else
                        // One-shot end: done coincides with the first IDLE cycle.
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, captured parameters, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= 3'd0;
            int_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            addr_q   <= 3'd0;
            data_q   <= 5'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            int_q    <= int_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
        end
    end

    assign sg_write_strobe = strobe_q;
    assign sg_address      = addr_q;
    assign sg_data         = data_q;
    assign busy            = busy_q;
    assign step_idx        = idx_q;
    assign done            = done_q;

endmodule
